// File: rtl/fc_operand_feeder.sv
// rtl/fc_operand_feeder.sv - FC layer operand feeder: streams (activation, weight) pairs per output neuron
//
// Walks the activation buffer (address i) and the weight ROM (linear address
// n*INPUT_SIZE + i) for OUTPUT_SIZE neurons. It hands each pair to the FC layer
// over a valid/ready stream, then waits for fc_done and pulses done.
//
// Optional build macro: FC_FEEDER_TIMEOUT_EN adds a watchdog on WAIT_FC that
// raises a sticky err after TIMEOUT_CYCLES cycles without fc_done.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a layer pass (sampled only in IDLE)
//   busy, done, err        status: not IDLE, end-of-pass pulse, sticky watchdog error
//   act_addr, act_rdata    activation buffer read port (1-cycle sync read)
//   wgt_addr, wgt_rdata    weight ROM read port (1-cycle sync read)
//   rd_en                  read strobe shared by both memories
//   a, b, op_valid,        operand pair stream to the FC layer
//   op_ready, op_last,
//   neuron_idx
//   fc_done                FC layer completion flag
module fc_operand_feeder #(
  parameter int DATA_WIDTH     = 12,
  parameter int INPUT_SIZE     = 400,
  parameter int OUTPUT_SIZE    = 120,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int WW = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1,
  localparam int NW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IW-1:0]         act_addr,
  input  logic [DATA_WIDTH-1:0] act_rdata,
  output logic [WW-1:0]         wgt_addr,
  input  logic [DATA_WIDTH-1:0] wgt_rdata,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  op_last,
  output logic [NW-1:0]         neuron_idx,
  input  logic                  fc_done
);

  localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUTPUT_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, WAIT_FC} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  last;
    logic [NW-1:0]         neuron;
  } pair_t;

  state_t        state, state_nxt;
  logic [IW-1:0] i_cnt;
  logic [NW-1:0] n_cnt;
  logic [WW-1:0] w_cnt;

  // Tag of the read issued last cycle; its data is on act_rdata/wgt_rdata now.
  logic          inflight;
  logic          inf_last;
  logic [NW-1:0] inf_neuron;

  pair_t         fifo_q [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;

  pair_t         in_pair, head;
  logic          read_last, hs, push, pop, timeout;

  assign read_last = (i_cnt == I_LAST) && (n_cnt == N_LAST);

  // Credit check: buffered pairs plus the read returning this cycle must leave
  // room for the new read, so the FIFO never overflows.
  assign rd_en    = (state == FEED) && ((fifo_cnt + {1'b0, inflight}) < 2'd2);
  assign op_valid = (fifo_cnt != 2'd0) || inflight;

  assign in_pair = '{a: act_rdata, b: wgt_rdata, last: inf_last, neuron: inf_neuron};

  // Returning data bypasses the empty FIFO so the first pair appears the cycle
  // after its read; once stalled it sits in the FIFO and stays stable.
  always_comb begin
    head = '0;
    if (fifo_cnt != 2'd0) head = fifo_q[rd_ptr];
    else if (inflight)    head = in_pair;
  end

  assign hs   = op_valid && op_ready;
  assign pop  = hs && (fifo_cnt != 2'd0);
  assign push = inflight && !(hs && (fifo_cnt == 2'd0));

  assign a          = head.a;
  assign b          = head.b;
  assign op_last    = head.last;
  assign neuron_idx = head.neuron;
  assign act_addr   = i_cnt;
  assign wgt_addr   = w_cnt;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (rd_en && read_last) state_nxt = DRAIN;
      DRAIN:   if (hs && head.last && (head.neuron == N_LAST)) state_nxt = WAIT_FC;
      WAIT_FC: if (fc_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      i_cnt      <= '0;
      n_cnt      <= '0;
      w_cnt      <= '0;
      inflight   <= 1'b0;
      inf_last   <= 1'b0;
      inf_neuron <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == WAIT_FC) && (fc_done || timeout);

      if (state == IDLE && start) begin
        i_cnt <= '0;
        n_cnt <= '0;
        w_cnt <= '0;
      end else if (rd_en) begin
        w_cnt <= read_last ? '0 : w_cnt + 1'b1;
        if (i_cnt == I_LAST) begin
          i_cnt <= '0;
          n_cnt <= read_last ? '0 : n_cnt + 1'b1;
        end else begin
          i_cnt <= i_cnt + 1'b1;
        end
      end

      inflight <= rd_en;
      if (rd_en) begin
        inf_last   <= (i_cnt == I_LAST);
        inf_neuron <= n_cnt;
      end

      if (push) begin
        fifo_q[wr_ptr] <= in_pair;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FC_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt;
  logic          err_q;

  assign timeout = (state == WAIT_FC) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_FC) ? to_cnt + 1'b1 : '0;
      if (state == IDLE && start) err_q <= 1'b0;
      else if (timeout)           err_q <= 1'b1;
    end
  end
`else
  // Watchdog not built; a negative limit is impossible, so this is always 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_fc_operand_feeder.sv
// tb/tb_fc_operand_feeder.sv - randomized self-checking bench for fc_operand_feeder
module tb_fc_operand_feeder;

  localparam int DW    = 12;
  localparam int IS    = 4;
  localparam int OS    = 3;
  localparam int TO    = 8;
  localparam int TOTAL = IS * OS;
  localparam int AW    = 2;
  localparam int WW    = 4;
  localparam int NW    = 2;
  localparam int PW    = 2 * DW + 1 + NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          fc_done = 1'b0;
  logic          op_ready = 1'b0;
  logic          busy, done, err, rd_en, op_valid, op_last;
  logic [AW-1:0] act_addr;
  logic [WW-1:0] wgt_addr;
  logic [DW-1:0] act_rdata = '0;
  logic [DW-1:0] wgt_rdata = '0;
  logic [DW-1:0] a, b;
  logic [NW-1:0] neuron_idx;

  fc_operand_feeder #(
    .DATA_WIDTH(DW), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .act_addr(act_addr), .act_rdata(act_rdata), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .rd_en(rd_en), .a(a), .b(b), .op_valid(op_valid), .op_ready(op_ready),
    .op_last(op_last), .neuron_idx(neuron_idx), .fc_done(fc_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] act_mem [IS];
  logic [DW-1:0] wgt_mem [16];

  always @(posedge clk) begin
    if (rd_en) begin
      act_rdata <= act_mem[act_addr];
      wgt_rdata <= wgt_mem[wgt_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit ready_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    op_ready = ready_rand ? ($urandom_range(99) < 30) : 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: pair k is activation k mod IS with weight k, last at the end of each neuron.
  function automatic logic [PW-1:0] exp_pair(input int k);
    logic last_k;
    logic [NW-1:0] nrn;
    last_k = ((k % IS) == IS - 1);
    nrn    = NW'(k / IS);
    return {act_mem[k % IS], wgt_mem[k], last_k, nrn};
  endfunction

  int            pair_cnt, issued, done_cnt, done_cyc, stall_viol, max_out, extra_pairs;
  int            first_hs, last_hs, start_cyc;
  logic          busy_at_done;
  bit            prev_stall;
  logic [PW-1:0] prev_pair;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        check("act_addr", 64'(act_addr), 64'(issued % IS));
        check("wgt_addr", 64'(wgt_addr), 64'(issued));
        issued++;
      end
      if (prev_stall && (!op_valid || {a, b, op_last, neuron_idx} != prev_pair))
        stall_viol++;
      if (op_valid && op_ready) begin
        if (pair_cnt < TOTAL)
          check("pair", 64'({a, b, op_last, neuron_idx}), 64'(exp_pair(pair_cnt)));
        else
          extra_pairs++;
        if (pair_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        pair_cnt++;
      end
      if (issued - pair_cnt > max_out) max_out = issued - pair_cnt;
      prev_stall = op_valid && !op_ready;
      prev_pair  = {a, b, op_last, neuron_idx};
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check(tag, 64'({busy, done, err, op_valid, op_last, rd_en, a, b, act_addr, wgt_addr, neuron_idx}), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    for (int c = 0; c < 200 && cyc < target; c++) tick();
  endtask

  task automatic begin_pass();
    for (int k = 0; k < IS; k++) act_mem[k] = DW'($urandom);
    for (int k = 0; k < 16; k++) wgt_mem[k] = DW'($urandom);
    pair_cnt = 0; issued = 0; done_cnt = 0; done_cyc = -1; stall_viol = 0;
    max_out = 0; extra_pairs = 0; first_hs = -1; last_hs = -1; busy_at_done = 1'b1;
    tick();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_after_start", 64'(err), 64'd0);
    check("rd_en_first", 64'(rd_en), 64'd1);
  endtask

  task automatic wait_pairs(input int n);
    for (int c = 0; c < 400 && pair_cnt < n; c++) tick();
    check("pairs_reached", 64'(pair_cnt), 64'(n));
  endtask

  task automatic pulse_fc_done_and_finish();
    int fc_cyc;
    fc_done = 1'b1;
    fc_cyc  = cyc;
    tick();
    fc_done = 1'b0;
    for (int c = 0; c < 20 && done_cnt == 0; c++) tick();
    repeat (3) tick();
    check("done_cycle", 64'(done_cyc), 64'(fc_cyc + 1));
    check("done_count", 64'(done_cnt), 64'd1);
    check("busy_at_done", 64'(busy_at_done), 64'd0);
    check("total_pairs", 64'(pair_cnt + extra_pairs), 64'(TOTAL));
    check("stall_stable", 64'(stall_viol), 64'd0);
    check("max_outstanding_ok", 64'(max_out <= 2), 64'd1);
    check("err_clear", 64'(err), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_outputs_zero("reset_values");
    rst_n = 1'b1;
    tick();
    check_outputs_zero("idle_values");

    // Basic pass
    ready_rand = 1'b0;
    begin_pass();
    wait_pairs(TOTAL);
    check("first_hs_cycle", 64'(first_hs), 64'(start_cyc + 2));
    check("last_hs_cycle", 64'(last_hs), 64'(start_cyc + TOTAL + 1));
    wait_cyc(start_cyc + 20);
    check("busy_in_wait_fc", 64'(busy), 64'd1);
    pulse_fc_done_and_finish();

    // Backpressure
    for (int r = 0; r < 3; r++) begin
      ready_rand = 1'b1;
      begin_pass();
      wait_pairs(TOTAL);
      ready_rand = 1'b0;
      tick();
      pulse_fc_done_and_finish();
    end

    // Busy start
    begin_pass();
    wait_cyc(start_cyc + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pairs(TOTAL);
    tick();
    pulse_fc_done_and_finish();
    repeat (4) tick();
    check("no_restart_busy", 64'(busy), 64'd0);

    // Reset mid-pass
    begin_pass();
    wait_pairs(6);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("no_done_after_reset", 64'(done_cnt), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);
    begin_pass();
    wait_pairs(TOTAL);
    pulse_fc_done_and_finish();

    // Early fc_done during FEED
    begin_pass();
    wait_cyc(start_cyc + 3);
    fc_done = 1'b1;
    repeat (3) tick();
    fc_done = 1'b0;
    wait_pairs(TOTAL);
    repeat (4) tick();
    check("early_fc_no_done", 64'(done_cnt), 64'd0);
    check("early_fc_still_busy", 64'(busy), 64'd1);
    pulse_fc_done_and_finish();

`ifdef FC_FEEDER_TIMEOUT_EN
    // Watchdog
    begin_pass();
    wait_pairs(TOTAL);
    for (int c = 0; c < 40 && done_cnt == 0; c++) tick();
    repeat (2) tick();
    check("wd_done_cycle", 64'(done_cyc), 64'(last_hs + 1 + TO));
    check("wd_done_count", 64'(done_cnt), 64'd1);
    check("wd_err_set", 64'(err), 64'd1);
    check("wd_idle", 64'(busy), 64'd0);
    begin_pass();
    wait_pairs(TOTAL);
    pulse_fc_done_and_finish();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
